face_detection_host_ctrl: RTL and testbench

FPGA-side sequencer for the Linux/FPGA mailbox protocol of the face detection IP. It decodes command codes written by the host over the single-word slave port, drives status codes and result words back on s_readdata, and forwards pixels to the detection datapath. It also counts pixels per frame and drains detection results from the result buffer. It sits between the Avalon-style slave port and the pixel/result datapath inside face_detection_ip.

---
 rtl/face_detection_host_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_face_detection_host_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/face_detection_host_ctrl.sv
// rtl/face_detection_host_ctrl.sv - host mailbox sequencer for the face detection IP
//
// Decodes command codes from the single-word host slave port, returns status
// codes or result words on s_readdata, forwards pixels to the detection
// datapath with a valid/ready handshake, tracks the pixel position within the
// frame and drains the result buffer one word per host request.
//
// Ports:
//   s_clk, s_reset        clock, asynchronous active-high reset
//   s_read                host read strobe (informational; status always valid)
//   s_readdata            registered status code or result word
//   s_write, s_writedata  host write strobe and command code / pixel value
//   core_reset            one-cycle datapath reset on host RESET command
//   pix_valid, pix_data   pixel offered to the datapath
//   pix_ready             datapath accepts the pixel when high with pix_valid
//   frame_end             one-cycle pulse on acceptance of the last frame pixel
//   det_done              datapath finished the current frame (level)
//   res_empty, res_data   result buffer empty flag and head word
//   res_pop               one-cycle pop of the result buffer head

module face_detection_host_ctrl #(
    parameter int DATA_WIDTH   = 13,
    parameter int PIXEL_WIDTH  = 8,
    parameter int FRAME_WIDTH  = 800,
    parameter int FRAME_HEIGHT = 600
) (
    input  logic                   s_clk,
    input  logic                   s_reset,
    input  logic                   s_read,
    output logic [DATA_WIDTH-1:0]  s_readdata,
    input  logic                   s_write,
    input  logic [DATA_WIDTH-1:0]  s_writedata,
    output logic                   core_reset,
    output logic                   pix_valid,
    output logic [PIXEL_WIDTH-1:0] pix_data,
    input  logic                   pix_ready,
    output logic                   frame_end,
    input  logic                   det_done,
    input  logic                   res_empty,
    input  logic [DATA_WIDTH-1:0]  res_data,
    output logic                   res_pop
);

    localparam int XW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
    localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

    // Host command codes
    localparam logic [DATA_WIDTH-1:0] CMD_START_SEND = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] CMD_START_RX   = DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] CMD_STOP_RX    = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] CMD_RESET      = DATA_WIDTH'(5);

    // FPGA status codes
    localparam logic [DATA_WIDTH-1:0] STS_IDLE        = DATA_WIDTH'(10);
    localparam logic [DATA_WIDTH-1:0] STS_RX_PIXEL    = DATA_WIDTH'(11);
    localparam logic [DATA_WIDTH-1:0] STS_STOP_RX_PIX = DATA_WIDTH'(12);
    localparam logic [DATA_WIDTH-1:0] STS_SEND_RESULT = DATA_WIDTH'(13);
    localparam logic [DATA_WIDTH-1:0] STS_STOP_RESULT = DATA_WIDTH'(14);
    localparam logic [DATA_WIDTH-1:0] STS_FINISH      = DATA_WIDTH'(15);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_CMD,
        ST_PIX_WAIT,
        ST_PIX_HOLD,
        ST_RES_WAIT,
        ST_RES_ANNOUNCE,
        ST_RES_DATA,
        ST_RES_NEXT,
        ST_FINISH
    } state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          hold_done;   // second cycle of the post-pop status hold reached

    logic unused_read;
    assign unused_read = s_read;

    logic wr_reset;
    assign wr_reset = s_write && (s_writedata == CMD_RESET);

    always_ff @(posedge s_clk or posedge s_reset) begin
        if (s_reset) begin
            state      <= ST_IDLE;
            s_readdata <= STS_IDLE;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            core_reset <= 1'b0;
            frame_end  <= 1'b0;
            res_pop    <= 1'b0;
            x          <= '0;
            y          <= '0;
            hold_done  <= 1'b0;
        end else begin
            core_reset <= 1'b0;
            frame_end  <= 1'b0;
            res_pop    <= 1'b0;

            // RESET overrides everything, including a pixel accepted this cycle
            if (wr_reset) begin
                core_reset <= 1'b1;
                x          <= '0;
                y          <= '0;
                pix_valid  <= 1'b0;
                hold_done  <= 1'b0;
                state      <= ST_WAIT_CMD;
                s_readdata <= STS_RX_PIXEL;
            end else begin
                case (state)
                    ST_IDLE: ;

                    ST_WAIT_CMD: begin
                        if (s_write && s_writedata == CMD_START_SEND) begin
                            state      <= ST_PIX_WAIT;
                            s_readdata <= STS_STOP_RX_PIX;
                        end else if (s_write && s_writedata == CMD_START_RX) begin
                            state      <= ST_RES_WAIT;
                            s_readdata <= STS_IDLE;
                        end
                    end

                    // Any non-RESET write here is pixel data, whatever its value
                    ST_PIX_WAIT: begin
                        if (s_write) begin
                            pix_data  <= s_writedata[PIXEL_WIDTH-1:0];
                            pix_valid <= 1'b1;
                            state     <= ST_PIX_HOLD;
                        end
                    end

                    ST_PIX_HOLD: begin
                        if (pix_ready) begin
                            pix_valid  <= 1'b0;
                            state      <= ST_WAIT_CMD;
                            s_readdata <= STS_RX_PIXEL;
                            if (x == X_LAST) begin
                                x <= '0;
                                if (y == Y_LAST) begin
                                    y         <= '0;
                                    frame_end <= 1'b1;
                                end else begin
                                    y <= y + 1'b1;
                                end
                            end else begin
                                x <= x + 1'b1;
                            end
                        end
                    end

                    ST_RES_WAIT: begin
                        if (!res_empty) begin
                            state      <= ST_RES_ANNOUNCE;
                            s_readdata <= STS_SEND_RESULT;
                        end else if (det_done) begin
                            state      <= ST_FINISH;
                            s_readdata <= STS_FINISH;
                        end
                    end

                    // Latch the head word so it stays stable while the host reads
                    ST_RES_ANNOUNCE: begin
                        state      <= ST_RES_DATA;
                        s_readdata <= res_data;
                    end

                    ST_RES_DATA: begin
                        if (s_write && s_writedata == CMD_STOP_RX) begin
                            res_pop    <= 1'b1;
                            hold_done  <= 1'b0;
                            state      <= ST_RES_NEXT;
                            s_readdata <= STS_STOP_RESULT;
                        end
                    end

                    // Give the buffer two cycles to present its new head/empty flag
                    ST_RES_NEXT: begin
                        if (!hold_done) begin
                            hold_done <= 1'b1;
                        end else if (s_write && s_writedata == CMD_START_RX) begin
                            state      <= ST_RES_WAIT;
                            s_readdata <= STS_IDLE;
                        end else if (res_empty && det_done) begin
                            state      <= ST_FINISH;
                            s_readdata <= STS_FINISH;
                        end
                    end

                    ST_FINISH: ;

                    default: begin
                        state      <= ST_IDLE;
                        s_readdata <= STS_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_face_detection_host_ctrl.sv
// tb/tb_face_detection_host_ctrl.sv - self-checking bench for face_detection_host_ctrl

module tb_face_detection_host_ctrl;

    localparam int DW  = 13;
    localparam int PW  = 8;
    localparam int FW  = 8;
    localparam int FH  = 4;
    localparam int NPIX = FW * FH;

    logic          s_clk;
    logic          s_reset;
    logic          s_read;
    logic [DW-1:0] s_readdata;
    logic          s_write;
    logic [DW-1:0] s_writedata;
    logic          core_reset;
    logic          pix_valid;
    logic [PW-1:0] pix_data;
    logic          pix_ready;
    logic          frame_end;
    logic          det_done;
    logic          res_empty = 1'b1;
    logic [DW-1:0] res_data  = '0;
    logic          res_pop;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int fe_cnt  = 0;
    int pop_cnt = 0;

    logic [PW-1:0] pix_q[$];     // expected pixels, pushed when written
    logic [DW-1:0] exp_res_q[$]; // expected result words, pushed when loaded
    logic [DW-1:0] res_buf[$];   // result buffer model feeding the DUT

    face_detection_host_ctrl #(
        .DATA_WIDTH  (DW),
        .PIXEL_WIDTH (PW),
        .FRAME_WIDTH (FW),
        .FRAME_HEIGHT(FH)
    ) dut (
        .s_clk      (s_clk),
        .s_reset    (s_reset),
        .s_read     (s_read),
        .s_readdata (s_readdata),
        .s_write    (s_write),
        .s_writedata(s_writedata),
        .core_reset (core_reset),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .frame_end  (frame_end),
        .det_done   (det_done),
        .res_empty  (res_empty),
        .res_data   (res_data),
        .res_pop    (res_pop)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks happen there too
    task automatic tick(input int n);
        repeat (n) @(posedge s_clk);
        #2;
    endtask

    task automatic wr(input logic [DW-1:0] v);
        tick(1);
        s_write     = 1'b1;
        s_writedata = v;
        tick(1);
        s_write     = 1'b0;
    endtask

    // Mid-cycle monitor: pixel acceptance scoreboard, frame_end count, result buffer
    always @(negedge s_clk) begin
        if (!s_reset && pix_valid && pix_ready && !(s_write && s_writedata == DW'(5))) begin
            acc_cnt++;
            chk("pix_q_level", 32'(pix_q.size() != 0), 32'd1);
            if (pix_q.size() != 0) chk("pix_data_accept", 32'(pix_data), 32'(pix_q.pop_front()));
        end
        if (frame_end) fe_cnt++;
        if (res_pop) begin
            pop_cnt++;
            if (res_buf.size() != 0) void'(res_buf.pop_front());
        end
        res_empty = (res_buf.size() == 0);
        res_data  = (res_buf.size() != 0) ? res_buf[0] : '0;
    end

    logic [PW-1:0] pv;

    initial begin
        s_reset = 1'b1; s_read = 1'b0; s_write = 1'b0; s_writedata = '0;
        pix_ready = 1'b0; det_done = 1'b0;
        tick(2);
        s_reset = 1'b0;

        // Reset state
        chk("rst_status", 32'(s_readdata), 32'd10);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_pix_data", 32'(pix_data), 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd0);
        chk("rst_res_pop", 32'(res_pop), 32'd0);
        wr(DW'(1));
        chk("idle_ignores_cmd", 32'(s_readdata), 32'd10);

        // Asynchronous reset mid-cycle while a pixel is held
        wr(DW'(5)); wr(DW'(1)); wr(DW'(8'h55));
        chk("pre_async_valid", 32'(pix_valid), 32'd1);
        #1 s_reset = 1'b1;
        #1;
        chk("async_status", 32'(s_readdata), 32'd10);
        chk("async_pix_valid", 32'(pix_valid), 32'd0);
        chk("async_res_pop", 32'(res_pop), 32'd0);
        tick(1);
        s_reset = 1'b0;

        // Pixel path
        pix_ready = 1'b1;
        wr(DW'(5));
        chk("p_core_reset_hi", 32'(core_reset), 32'd1);
        chk("p_status_11", 32'(s_readdata), 32'd11);
        wr(DW'(1));
        chk("p_core_reset_lo", 32'(core_reset), 32'd0);
        chk("p_status_12", 32'(s_readdata), 32'd12);
        pix_q.push_back(8'h2A);
        wr(DW'(8'h2A));
        chk("p_valid", 32'(pix_valid), 32'd1);
        chk("p_data", 32'(pix_data), 32'h2A);
        chk("p_status_hold", 32'(s_readdata), 32'd12);
        tick(1);
        chk("p_valid_drop", 32'(pix_valid), 32'd0);
        chk("p_status_back", 32'(s_readdata), 32'd11);
        chk("p_accept_cnt", 32'(acc_cnt), 32'd1);

        // Backpressure, with a dropped STOP_SEND
        pix_ready = 1'b0;
        wr(DW'(1));
        pix_q.push_back(8'h2A);
        wr(DW'(8'h2A));
        tick(1);
        wr(DW'(2));
        tick(1);
        chk("bp_valid", 32'(pix_valid), 32'd1);
        chk("bp_data", 32'(pix_data), 32'h2A);
        chk("bp_status", 32'(s_readdata), 32'd12);
        pix_ready = 1'b1;
        tick(1);
        chk("bp_released", 32'(pix_valid), 32'd0);
        chk("bp_status_11", 32'(s_readdata), 32'd11);
        chk("bp_accept_cnt", 32'(acc_cnt), 32'd2);
        chk("bp_x", 32'(dut.x), 32'd2);

        // RESET coinciding with pixel acceptance: reset wins, pixel not counted
        pix_ready = 1'b0;
        wr(DW'(1)); wr(DW'(8'h99));
        tick(1);
        pix_ready = 1'b1; s_write = 1'b1; s_writedata = DW'(5);
        tick(1);
        s_write = 1'b0;
        chk("rw_status", 32'(s_readdata), 32'd11);
        chk("rw_valid", 32'(pix_valid), 32'd0);
        chk("rw_core_reset", 32'(core_reset), 32'd1);
        chk("rw_x", 32'(dut.x), 32'd0);
        chk("rw_accept_cnt", 32'(acc_cnt), 32'd2);

        // Full frame
        for (int i = 0; i < NPIX; i++) begin
            wr(DW'(1));
            pv = 8'(i * 7 + 3);
            pix_q.push_back(pv);
            wr(DW'(pv));
            tick(1);
            if (i == NPIX - 2) chk("fe_before_last", 32'(fe_cnt), 32'd0);
        end
        chk("fe_on_last", 32'(frame_end), 32'd1);
        tick(1);
        chk("fe_once", 32'(fe_cnt), 32'd1);
        chk("fe_pulse_low", 32'(frame_end), 32'd0);
        chk("fe_x", 32'(dut.x), 32'd0);
        chk("fe_y", 32'(dut.y), 32'd0);
        chk("fe_accepts", 32'(acc_cnt), 32'(2 + NPIX));

        // Result drain
        res_buf.push_back(DW'(12'h123)); exp_res_q.push_back(DW'(12'h123));
        res_buf.push_back(DW'(12'h456)); exp_res_q.push_back(DW'(12'h456));
        det_done = 1'b1;
        wr(DW'(4));
        chk("stray_stop_no_pop", 32'(pop_cnt), 32'd0);
        for (int k = 0; k < 2; k++) begin
            wr(DW'(3));
            chk("r_status_10", 32'(s_readdata), 32'd10);
            tick(1);
            chk("r_status_13", 32'(s_readdata), 32'd13);
            tick(1);
            chk("r_data", 32'(s_readdata), 32'(exp_res_q.pop_front()));
            tick(2);
            chk("r_data_stable", 32'(s_readdata), 32'(k == 0 ? 12'h123 : 12'h456));
            wr(DW'(4));
            chk("r_status_14", 32'(s_readdata), 32'd14);
            chk("r_pop_pulse", 32'(res_pop), 32'd1);
            tick(1);
            chk("r_status_14_hold", 32'(s_readdata), 32'd14);
            chk("r_pop_low", 32'(res_pop), 32'd0);
        end
        tick(1);
        chk("r_finish", 32'(s_readdata), 32'd15);
        chk("r_pop_cnt", 32'(pop_cnt), 32'd2);
        wr(DW'(1)); wr(DW'(4));
        chk("fin_hold", 32'(s_readdata), 32'd15);
        chk("fin_no_pop", 32'(pop_cnt), 32'd2);

        // RESET in the middle of a result transfer
        det_done = 1'b0;
        wr(DW'(5));
        res_buf.push_back(DW'(12'h777));
        wr(DW'(3));
        tick(2);
        chk("mr_data", 32'(s_readdata), 32'h777);
        wr(DW'(5));
        chk("mr_status", 32'(s_readdata), 32'd11);
        chk("mr_core_reset", 32'(core_reset), 32'd1);
        chk("mr_no_pop", 32'(res_pop), 32'd0);
        tick(1);
        chk("mr_pop_cnt", 32'(pop_cnt), 32'd2);
        chk("mr_core_reset_lo", 32'(core_reset), 32'd0);

        chk("pix_q_drained", 32'(pix_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
